// File: rtl/mining_work_loader_pkg.sv
// Shared definitions for the miner work loader: frame geometry, payload field
// offsets, the committed work record and the receive/run state encodings.
package mining_work_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int PAYLOAD_BYTES = 80;
  localparam int PAYLOAD_W     = PAYLOAD_BYTES * 8;

  // Bit offsets inside the 640-bit shadow; the first byte received lands at the top.
  localparam int OFF_DIGEST_INITIAL = 384;
  localparam int OFF_DIGEST_IN      = 128;
  localparam int OFF_MERKLE         = 96;
  localparam int OFF_TIME           = 64;
  localparam int OFF_TARGET         = 32;
  localparam int OFF_NONCE          = 0;

  typedef struct packed {
    logic [255:0] digest_initial;
    logic [255:0] digest_in;
    logic [31:0]  merkle;
    logic [31:0]  time_val;
    logic [31:0]  target;
    logic [31:0]  nonce;
  } work_t;

  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_CSUM} rx_state_e;
  typedef enum logic [2:0] {STOPPED, HRST, ARM, RUNNING, SOLVED} run_state_e;

endpackage

// File: rtl/mining_work_loader_if.sv
// Byte-wide receive link between the UART/SPI front-end and the work loader.
interface mining_work_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/mining_work_loader_frame_rx.sv
// Frame receiver: hunts for the sync byte, shifts in 80 payload bytes with a
// running XOR, then judges the checksum byte and emits commit/err strobes.
module mining_frame_rx
  import mining_work_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [7:0]           rx_byte,
  input  logic                 rx_fire,
  output logic [PAYLOAD_W-1:0] payload,
  output logic                 commit,
  output logic                 frame_err,
  output logic                 busy
);

  rx_state_e  state_q, state_d;
  logic [6:0] cnt_q;
  logic [7:0] csum_q;
  logic       csum_byte;

  assign csum_byte = (state_q == R_CSUM) && rx_fire;
  // Combinational so the work registers update on the edge that takes the checksum.
  assign commit    = csum_byte && (rx_byte == csum_q);
  assign busy      = (state_q != R_IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      R_IDLE: if (rx_fire && rx_byte == SYNC_BYTE) state_d = R_LOAD;
      R_LOAD: if (rx_fire && cnt_q == 7'(PAYLOAD_BYTES - 1)) state_d = R_CSUM;
      R_CSUM: if (rx_fire) state_d = R_IDLE;
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= R_IDLE;
      cnt_q     <= '0;
      csum_q    <= '0;
      payload   <= '0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_err <= csum_byte && (rx_byte != csum_q);
      if (state_q == R_IDLE) begin
        cnt_q  <= '0;
        csum_q <= '0;
      end else if (state_q == R_LOAD && rx_fire) begin
        payload <= {payload[PAYLOAD_W-9:0], rx_byte};
        csum_q  <= csum_q ^ rx_byte;
        cnt_q   <= cnt_q + 7'd1;
      end
    end
  end

endmodule

// File: rtl/mining_work_loader.sv
// Work loader top: commits validated frames to stable work registers and
// sequences the miner core's reset/run lines, latching the solved status.
module mining_work_loader
  import mining_work_loader_pkg::*;
#(
  parameter int         RST_CYCLES = 2,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  mining_work_loader_if.slave  rx,
  output logic [255:0]         digest_initial,
  output logic [255:0]         digest_in,
  output logic [31:0]          merkle,
  output logic [31:0]          time_val,
  output logic [31:0]          target,
  output logic [31:0]          nonce,
  output logic                 hash_rst_n,
  output logic                 hash_write_en,
  input  logic                 solution_valid,
  output logic                 solved,
  output logic                 frame_err,
  output logic                 busy
);

  logic                 rdy_q;
  logic                 rx_fire;
  logic [PAYLOAD_W-1:0] payload;
  logic                 commit;
  work_t                work_q;
  run_state_e           run_q, run_d;
  logic [3:0]           hcnt_q;

  assign rx.rx_ready = rdy_q;
  assign rx_fire     = rx.rx_valid && rdy_q;

  mining_frame_rx #(.SYNC_BYTE(SYNC_BYTE)) u_rx (
    .CLK       (CLK),
    .RST       (RST),
    .rx_byte   (rx.rx_data),
    .rx_fire   (rx_fire),
    .payload   (payload),
    .commit    (commit),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rdy_q  <= 1'b0;
      work_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (commit)
        work_q <= '{digest_initial: payload[OFF_DIGEST_INITIAL +: 256],
                    digest_in:      payload[OFF_DIGEST_IN +: 256],
                    merkle:         payload[OFF_MERKLE +: 32],
                    time_val:       payload[OFF_TIME +: 32],
                    target:         payload[OFF_TARGET +: 32],
                    nonce:          payload[OFF_NONCE +: 32]};
    end
  end

  assign digest_initial = work_q.digest_initial;
  assign digest_in      = work_q.digest_in;
  assign merkle         = work_q.merkle;
  assign time_val       = work_q.time_val;
  assign target         = work_q.target;
  assign nonce          = work_q.nonce;

  // A fresh commit overrides everything, including a same-cycle solution.
  always_comb begin
    run_d = run_q;
    if (commit) run_d = HRST;
    else begin
      unique case (run_q)
        STOPPED: run_d = STOPPED;
        HRST:    if (hcnt_q == 4'(RST_CYCLES - 1)) run_d = ARM;
        ARM:     run_d = RUNNING;
        RUNNING: if (solution_valid) run_d = SOLVED;
        SOLVED:  run_d = SOLVED;
        default: run_d = STOPPED;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      run_q  <= STOPPED;
      hcnt_q <= '0;
    end else begin
      run_q  <= run_d;
      hcnt_q <= (commit || run_q != HRST) ? 4'd0 : hcnt_q + 4'd1;
    end
  end

  assign hash_rst_n    = (run_q == ARM) || (run_q == RUNNING) || (run_q == SOLVED);
  assign hash_write_en = (run_q == RUNNING) || (run_q == SOLVED);
  assign solved        = (run_q == SOLVED);

endmodule

// File: tb/tb_mining_work_loader.sv
// Directed + randomized bench for mining_work_loader with a field-level frame model.
module tb_mining_work_loader;
  import mining_work_loader_pkg::*;

  localparam int RC = 2;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  mining_work_loader_if rx_if ();

  logic [255:0] digest_initial, digest_in;
  logic [31:0]  merkle, time_val, target, nonce;
  logic         hash_rst_n, hash_write_en, solution_valid, solved, frame_err, busy;

  mining_work_loader #(.RST_CYCLES(RC), .SYNC_BYTE(8'hA5)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .rx             (rx_if),
    .digest_initial (digest_initial),
    .digest_in      (digest_in),
    .merkle         (merkle),
    .time_val       (time_val),
    .target         (target),
    .nonce          (nonce),
    .hash_rst_n     (hash_rst_n),
    .hash_write_en  (hash_write_en),
    .solution_valid (solution_valid),
    .solved         (solved),
    .frame_err      (frame_err),
    .busy           (busy)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [639:0] exp_work = '0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_if.rx_data  = b;
    rx_if.rx_valid = 1'b1;
    step();
  endtask

  task automatic send_garbage(input int n);
    logic [7:0] g;
    for (int i = 0; i < n; i++) begin
      g = 8'($urandom_range(0, 255));
      if (g == 8'hA5) g = 8'h5A;
      send_byte(g);
    end
  endtask

  // Serialize fields MSB-first, append XOR checksum (optionally corrupted).
  task automatic send_frame(input logic [639:0] w, input logic [7:0] xmask, input bit sol_on_csum);
    logic [7:0] b, cs;
    cs = 8'h00;
    send_byte(8'hA5);
    for (int i = 0; i < 80; i++) begin
      b = w[639 - 8*i -: 8];
      cs ^= b;
      send_byte(b);
    end
    if (sol_on_csum) solution_valid = 1'b1;
    send_byte(cs ^ xmask);
    solution_valid = 1'b0;
    rx_if.rx_valid = 1'b0;
  endtask

  function automatic logic [639:0] rand_work();
    logic [639:0] c;
    c = '0;
    for (int i = 0; i < 20; i++) c = {c[607:0], 32'($urandom())};
    return c;
  endfunction

  task automatic check_work(input string tag, input logic [639:0] w);
    check({tag, ".digest_initial"}, digest_initial, w[639:384]);
    check({tag, ".digest_in"},      digest_in,      w[383:128]);
    check({tag, ".merkle"},         merkle,         {224'd0, w[127:96]});
    check({tag, ".time_val"},       time_val,       {224'd0, w[95:64]});
    check({tag, ".target"},         target,         {224'd0, w[63:32]});
    check({tag, ".nonce"},          nonce,          {224'd0, w[31:0]});
  endtask

  // Entered at N+1 after the checksum edge of a good frame.
  task automatic expect_commit_seq(input string tag, input bit sv_hold);
    solution_valid = sv_hold;
    check({tag, ".n1_rst_n"},  hash_rst_n,    0);
    check({tag, ".n1_wen"},    hash_write_en, 0);
    check({tag, ".n1_solved"}, solved,        0);
    for (int k = 2; k <= RC; k++) begin
      step();
      check({tag, ".hrst_rst_n"}, hash_rst_n, 0);
    end
    step();
    check({tag, ".arm_rst_n"}, hash_rst_n,    1);
    check({tag, ".arm_wen"},   hash_write_en, 0);
    step();
    solution_valid = 1'b0;
    check({tag, ".run_wen"},    hash_write_en, 1);
    check({tag, ".run_solved"}, solved,        0);
    step();
    check({tag, ".run2_solved"}, solved,        0);
    check({tag, ".run2_wen"},    hash_write_en, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [639:0] w;
    logic [7:0]   m;
    bit           bad;

    rx_if.rx_data  = 8'h00;
    rx_if.rx_valid = 1'b0;
    solution_valid = 1'b0;
    repeat (3) step();
    check("rst.rx_ready", rx_if.rx_ready, 0);
    check("rst.hash_rst_n", hash_rst_n, 0);
    check("rst.wen", hash_write_en, 0);
    check("rst.solved", solved, 0);
    check("rst.busy", busy, 0);
    check("rst.frame_err", frame_err, 0);
    check_work("rst", '0);
    RST = 1'b1;
    step();
    check("post_rst.rx_ready", rx_if.rx_ready, 1);

    // SHA IV frame with a corrupted checksum, then the same frame intact.
    w = rand_work();
    w[639:384] = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    w[31:0]    = 32'h0000_0100;
    send_frame(w, 8'h01, 1'b0);
    check("bad0.frame_err", frame_err, 1);
    check_work("bad0", exp_work);
    check("bad0.rst_n", hash_rst_n, 0);
    step();
    check("bad0.err_drop", frame_err, 0);
    check("bad0.rst_n2", hash_rst_n, 0);

    send_frame(w, 8'h00, 1'b0);
    exp_work = w;
    check("good0.frame_err", frame_err, 0);
    check_work("good0", exp_work);
    expect_commit_seq("good0", 1'b1);  // solution outside RUNNING is ignored

    solution_valid = 1'b1;
    step();
    solution_valid = 1'b0;
    check("sol.solved", solved, 1);
    check("sol.wen", hash_write_en, 1);
    step();
    check("sol.latched", solved, 1);

    // Garbage then a frame dense with sync-valued bytes.
    send_byte(8'h00);
    send_byte(8'hFF);
    w = rand_work();
    w[639:632] = 8'hA5;
    w[127:96]  = 32'hA5A5_A5A5;
    w[7:0]     = 8'hA5;
    send_frame(w, 8'h00, 1'b0);
    exp_work = w;
    check_work("a5", exp_work);
    expect_commit_seq("a5", 1'b0);

    // Bad frame while running must not disturb the miner.
    m = 8'($urandom_range(1, 255));
    send_frame(rand_work(), m, 1'b0);
    check("badrun.frame_err", frame_err, 1);
    check("badrun.wen", hash_write_en, 1);
    check("badrun.rst_n", hash_rst_n, 1);
    check_work("badrun", exp_work);

    // Commit coincident with a solution: commit wins.
    w = rand_work();
    send_frame(w, 8'h00, 1'b1);
    exp_work = w;
    check_work("cosol", exp_work);
    expect_commit_seq("cosol", 1'b0);

    for (int it = 0; it < 4; it++) begin
      send_garbage(int'($urandom_range(0, 2)));
      w   = rand_work();
      bad = 1'($urandom_range(0, 1));
      m   = bad ? 8'($urandom_range(1, 255)) : 8'h00;
      send_frame(w, m, 1'b0);
      check("rnd.frame_err", frame_err, {255'd0, bad});
      if (!bad) exp_work = w;
      check_work("rnd", exp_work);
      if (bad) check("rnd.wen", hash_write_en, 1);
      else     expect_commit_seq("rnd", 1'b0);
    end

    // Reset mid-frame, then a clean frame.
    send_byte(8'hA5);
    w = rand_work();
    for (int i = 0; i < 40; i++) send_byte(w[639 - 8*i -: 8]);
    check("mid.busy", busy, 1);
    rx_if.rx_valid = 1'b0;
    RST = 1'b0;
    step();
    check("mid.busy_clr", busy, 0);
    check("mid.rst_n", hash_rst_n, 0);
    check("mid.wen", hash_write_en, 0);
    check_work("mid", '0);
    RST = 1'b1;
    step();
    w = rand_work();
    send_frame(w, 8'h00, 1'b0);
    check_work("after_rst", w);
    expect_commit_seq("after_rst", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mining_work_loader.md
# mining_work_loader

Byte-stream work receiver that sits in front of the SHA double-hash miner core. It deserializes work frames (midstates, header words, starting nonce) from a byte-wide link (UART/SPI front-end), validates them with an XOR checksum, and commits them to stable work registers. It then sequences the miner's reset and write-enable lines and tracks run/solved status. It is the producer side of the miner's work interface; the miner consumes what this block commits.

## Interface
- RST_CYCLES, 2: cycles hash_rst_n is held low per commit (1..15)
- SYNC_BYTE, 8'hA5: frame start marker
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-low
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid & rx_ready; reset 0, 1 thereafter
- digest_initial  out  256  committed first-block SHA state; reset 0
- digest_in  out  256  committed midstate; reset 0
- merkle  out  32  committed merkle tail word; reset 0
- time_val  out  32  committed start time; reset 0
- target  out  32  committed compact target (nBits); reset 0
- nonce  out  32  committed start nonce; reset 0
- hash_rst_n  out  1  active-low reset to miner core; reset 0
- hash_write_en  out  1  miner run enable; reset 0
- solution_valid  in  1  miner solution flag (level)
- solved  out  1  latched solution status; reset 0
- frame_err  out  1  one-cycle pulse on checksum mismatch; reset 0
- busy  out  1  receive FSM not in R_IDLE; reset 0

## Operation
- Frame: SYNC_BYTE, 80 payload bytes, 1 checksum byte (XOR of the 80 payload bytes). Total 82 bytes.
- Payload order is MSB-first per field: digest_initial[255:248] first, then digest_in, merkle, time_val, target, nonce, ending with nonce[7:0].
- Receive FSM:
  - R_IDLE: non-sync bytes are discarded; SYNC_BYTE -> R_LOAD.
  - R_LOAD: each byte shifts into a 640-bit shadow register and updates the running XOR. A 7-bit counter runs 0..79; the byte at count 79 -> R_CSUM.
  - R_CSUM: next byte is the checksum. On match, commit (shadow -> outputs) and go to R_IDLE. On mismatch, pulse frame_err, leave outputs unchanged and go to R_IDLE.
- A SYNC_BYTE value inside the payload is data, not a resync.
- Run FSM:
  - STOPPED -> HRST on commit.
  - HRST: hash_rst_n=0, hash_write_en=0 for RST_CYCLES cycles -> ARM.
  - ARM: hash_rst_n=1, hash_write_en=0 for 1 cycle -> RUNNING.
  - RUNNING: hash_write_en=1; solution_valid -> SOLVED.
  - SOLVED: solved=1, hash_write_en stays 1 (the miner self-gates).
  - A commit from any state -> HRST and clears solved.
- The miner keeps running on old work while a new frame is received. Only a good commit disturbs it.

## Timing
- Checksum byte accepted at cycle N: outputs are updated and hash_rst_n=0 at N+1, hash_rst_n=1 at N+1+RST_CYCLES, hash_write_en=1 at N+2+RST_CYCLES.
- frame_err is high at N+1 only.
- Commit and solution_valid in the same cycle: the commit wins, the next state is HRST and solved stays 0.
- A commit during HRST/ARM restarts the HRST count from the new commit.
- solution_valid is ignored outside RUNNING.
- RST mid-frame: all state clears. The partial frame is dropped and hash_rst_n=0 until the next commit.
- rx_ready never drops after reset, so no bytes are lost at full rate.

## Structure
- Shared mining package:
  - SYNC_BYTE, payload length 80, field bit offsets within the 640-bit shadow.
  - Receive-state and run-state enums.
- Sub-module: mining_frame_rx (sync detect, shift register, counter, checksum), emitting the 640-bit payload plus commit/err strobes.
- The run FSM lives in the top.

## Test plan
- Good frame, digest_initial=256'h6a09e667...5be0cd19, nonce=32'h0000_0100, checksum correct -> outputs match at N+1; hash_rst_n low 2 cycles; hash_write_en=1 at N+4.
- Same frame with the checksum XORed by 8'h01 -> frame_err pulses once, outputs stay 0, hash_rst_n stays 0.
- Leading garbage 8'h00,8'hFF, then a frame whose payload contains 8'hA5 bytes -> correct commit with no early resync.
- RUNNING, assert solution_valid -> solved=1 and hash_write_en stays 1. Then send a new good frame -> solved=0 and the HRST sequence repeats.
- Bad-checksum frame sent while RUNNING -> hash_write_en and the outputs are undisturbed.
- RST asserted after byte 40 of a frame, then a full good frame -> clean commit; no residue from the partial frame.
